bolme_birimi: RTL and testbench
===============================

Name: bolme_birimi

Overview:
- Multi-cycle integer divider in the YURUT stage; executes RV32M DIV/DIVU/REM/REMU.
- Produces the execute-stage ready signal that the control/hazard unit consumes as yrt_hazir_i.
- Honours that unit's YURUT-stage stall and pipeline-flush outputs.
- Radix-2 restoring division, one quotient bit per cycle; special cases resolved early.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- basla_i  input  1  a divide op is present in YURUT this cycle (held while stage is stalled)
- islem_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with basla_i in BOS
- bolunen_i  input  XLEN  dividend (rs1)
- bolen_i  input  XLEN  divisor (rs2)
- durdur_i  input  1  YURUT stall from control unit; freezes the BITTI handoff
- iptal_i  input  1  flush (mispredict); aborts any op in progress
- hazir_o  output  1  0 while an op is in progress or being accepted; drives yrt_hazir_i
- sonuc_o  output  XLEN  result; valid only while in BITTI

Behaviour:
- States:
  - BOS (idle)
  - HESAPLA (iterating)
  - BITTI (result presented)
- Reset (synchronous): state BOS, counter 0, all datapath registers 0, sonuc_o 0. In BOS with basla_i=0, hazir_o is 1.
- hazir_o is combinational: 1 in BITTI, or in BOS with basla_i=0; 0 otherwise. It drops in the same cycle the op arrives, so the control unit stalls GETIR/COZ with no bubble.
- BOS, basla_i=1, iptal_i=0:
  - Latch islem_i, the operand absolute values, and the result sign.
  - Quotient sign = sign(a) XOR sign(b); signed ops only.
  - Remainder sign = sign(a); signed ops only.
  - DIVU/REMU treat operands as unsigned.
- Special cases; next state is BITTI (1-cycle latency):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - DIV/REM with dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Otherwise next state is HESAPLA, counter = 0.
- HESAPLA (one iteration per cycle):
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor using an XLEN+1-bit subtraction.
  - Restore on negative; set the quotient LSB on non-negative.
  - After XLEN iterations (counter = XLEN-1), go to BITTI.
- Normal latency: op presented in cycle 0, hazir_o low in cycles 0..XLEN, hazir_o high with a valid result in cycle XLEN+1.
- BITTI:
  - sonuc_o = sign-corrected (two's complement negate) quotient or remainder, selected by the latched op. May be combinational from registers.
  - durdur_i=1: stay in BITTI; sonuc_o and hazir_o stable.
  - durdur_i=0: go to BOS next cycle. The held basla_i of the finished op must not restart it, because the pipeline advances in this same cycle.
- iptal_i=1 in any state: next state BOS, in-flight op discarded. iptal_i has priority over basla_i in BOS, so no op is accepted that cycle.
  - hazir_o is not forced by iptal_i; the control unit already flushes.
- Back-to-back divides: a new basla_i is accepted in the first BOS cycle after BITTI.
- Reset mid-operation: returns to BOS on the next edge; no partial result is visible.
- Counter width is clog2(XLEN); no wrap beyond XLEN-1.

Test Plan:
- Reset, then idle: sonuc_o=0 and hazir_o=1. DIVU 100/7: hazir_o=0 in cycles 0..32; cycle 33 hazir_o=1 and sonuc_o=14. Repeat with REMU: sonuc_o=2.
- DIV 0xFFFFFFF9 (-7) / 2: sonuc_o=0xFFFFFFFD (-3). REM same operands: sonuc_o=0xFFFFFFFF (-1). REM 7/-2: sonuc_o=1.
- Divide by zero, DIV 5/0: hazir_o low only in cycle 0; cycle 1 sonuc_o=0xFFFFFFFF. REMU 5/0: sonuc_o=5.
- Overflow, DIV 0x80000000/0xFFFFFFFF: cycle 1 sonuc_o=0x80000000. REM same operands: sonuc_o=0.
- durdur_i=1 for 3 cycles on arrival in BITTI: state and sonuc_o held for 3 cycles, then BOS. The still-asserted basla_i during the hold must not cause a second computation.
- iptal_i at iteration 10: BOS next cycle, hazir_o=1. A new DIVU 9/3 presented afterwards returns 3 after 33 cycles.

Source files
------------

// File: rtl/bolme_birimi.sv
// Multi-cycle RV32M divider for the YURUT stage (DIV/DIVU/REM/REMU).
// Radix-2 restoring division, one quotient bit per cycle; divide-by-zero and overflow finish in one cycle.
module bolme_birimi #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            basla_i,
  input  logic [1:0]      islem_i,
  input  logic [XLEN-1:0] bolunen_i,
  input  logic [XLEN-1:0] bolen_i,
  input  logic            durdur_i,
  input  logic            iptal_i,
  output logic            hazir_o,
  output logic [XLEN-1:0] sonuc_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   SON       = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] EN_KUCUK  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {BOS, HESAPLA, BITTI} durum_t;

  durum_t          durum;
  logic [CW-1:0]   sayac;
  logic [XLEN-1:0] bolum;
  logic [XLEN-1:0] kalan;
  logic [XLEN-1:0] bolen_r;
  logic            kalan_sec;
  logic            isaret_b;
  logic            isaret_k;

  logic            isaretli;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mutlak_a;
  logic [XLEN-1:0] mutlak_b;
  logic [XLEN:0]   kaydir;
  logic [XLEN:0]   fark;

  always_comb begin
    isaretli = ~islem_i[0];
    a_neg    = isaretli & bolunen_i[XLEN-1];
    b_neg    = isaretli & bolen_i[XLEN-1];
    mutlak_a = a_neg ? (~bolunen_i + 1'b1) : bolunen_i;
    mutlak_b = b_neg ? (~bolen_i + 1'b1) : bolen_i;
    // Shifted partial remainder is below 2*divisor, so XLEN+1 bits hold the signed difference.
    kaydir   = {kalan, bolum[XLEN-1]};
    fark     = kaydir - {1'b0, bolen_r};
  end

  assign hazir_o = (durum == BITTI) || ((durum == BOS) && !basla_i);

  always_comb begin
    sonuc_o = '0;
    if (durum == BITTI) begin
      if (kalan_sec) sonuc_o = isaret_k ? (~kalan + 1'b1) : kalan;
      else           sonuc_o = isaret_b ? (~bolum + 1'b1) : bolum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum     <= BOS;
      sayac     <= '0;
      bolum     <= '0;
      kalan     <= '0;
      bolen_r   <= '0;
      kalan_sec <= 1'b0;
      isaret_b  <= 1'b0;
      isaret_k  <= 1'b0;
    end else if (iptal_i) begin
      durum <= BOS;
      sayac <= '0;
    end else begin
      case (durum)
        BOS: begin
          if (basla_i) begin
            kalan_sec <= islem_i[1];
            if (bolen_i == '0) begin
              bolum    <= '1;
              kalan    <= bolunen_i;
              isaret_b <= 1'b0;
              isaret_k <= 1'b0;
              durum    <= BITTI;
            end else if (isaretli && (bolunen_i == EN_KUCUK) && (bolen_i == '1)) begin
              bolum    <= EN_KUCUK;
              kalan    <= '0;
              isaret_b <= 1'b0;
              isaret_k <= 1'b0;
              durum    <= BITTI;
            end else begin
              bolum    <= mutlak_a;
              kalan    <= '0;
              bolen_r  <= mutlak_b;
              isaret_b <= a_neg ^ b_neg;
              isaret_k <= a_neg;
              sayac    <= '0;
              durum    <= HESAPLA;
            end
          end
        end
        HESAPLA: begin
          if (fark[XLEN]) begin
            kalan <= kaydir[XLEN-1:0];
            bolum <= {bolum[XLEN-2:0], 1'b0};
          end else begin
            kalan <= fark[XLEN-1:0];
            bolum <= {bolum[XLEN-2:0], 1'b1};
          end
          if (sayac == SON) durum <= BITTI;
          else              sayac <= sayac + 1'b1;
        end
        BITTI: begin
          // Leaving BITTI: the held basla_i belongs to the op just finished, so it is not sampled here.
          if (!durdur_i) durum <= BOS;
        end
        default: durum <= BOS;
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// Self-checking bench for bolme_birimi: directed RV32M cases, random ops against an arithmetic model,
// stall hold, flush, back-to-back issue and mid-operation reset.
module tb_bolme_birimi;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        basla_i = 1'b0;
  logic [1:0]  islem_i = 2'b00;
  logic [31:0] bolunen_i = '0;
  logic [31:0] bolen_i = '0;
  logic        durdur_i = 1'b0;
  logic        iptal_i = 1'b0;
  logic        hazir_o;
  logic [31:0] sonuc_o;

  int checks = 0;
  int errors = 0;

  bolme_birimi #(.XLEN(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .basla_i   (basla_i),
    .islem_i   (islem_i),
    .bolunen_i (bolunen_i),
    .bolen_i   (bolen_i),
    .durdur_i  (durdur_i),
    .iptal_i   (iptal_i),
    .hazir_o   (hazir_o),
    .sonuc_o   (sonuc_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain 64-bit arithmetic (truncating division), RISC-V rules for /0; overflow falls out naturally.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (op[0]) begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (b == 32'd0) begin
      q = -1;
      r = longint'({32'b0, a});
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic next_cycle();
    @(negedge clk_i);
    #1;
  endtask

  // Presents an op and returns in the first cycle hazir_o is high again (basla_i still held).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    @(negedge clk_i);
    basla_i = 1'b1; islem_i = op; bolunen_i = a; bolen_i = b;
    #1;
    lat = 0;
    while (!hazir_o && lat < 40) begin
      next_cycle();
      lat++;
    end
    res = sonuc_o;
  endtask

  task automatic release_op();
    next_cycle();
    basla_i = 1'b0;
    #1;
  endtask

  task automatic run_check(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    issue(op, a, b, lat, res);
    checks++;
    if (lat !== model_lat(op, a, b)) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", nm, lat, model_lat(op, a, b));
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s result got %h want %h", nm, res, exp);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) next_cycle();
    rst_i = 1'b0;
    next_cycle();
    checks++;
    if (hazir_o !== 1'b1 || sonuc_o !== 32'd0) begin
      errors++;
      $display("FAIL reset hazir=%b sonuc=%h want hazir=1 sonuc=0", hazir_o, sonuc_o);
    end
  endtask

  task automatic test_directed();
    run_check("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);        release_op();
    run_check("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);         release_op();
    run_check("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); release_op();
    run_check("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); release_op();
    run_check("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);   release_op();
    run_check("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);   release_op();
    run_check("remu_5_0",   2'b11, 32'd5, 32'd0, 32'd5);           release_op();
    run_check("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); release_op();
    run_check("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0); release_op();
    run_check("divu_big",   2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF); release_op();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 15));
        1: b = -32'($urandom_range(1, 15));
        2: b = 32'd0;
        default: b = $urandom;
      endcase
      run_check($sformatf("rand%0d", i), op, a, b, model(op, a, b));
      release_op();
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] res;
    issue(2'b00, 32'd1000, 32'hFFFF_FFF9, lat, res);
    durdur_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (hazir_o !== 1'b1 || sonuc_o !== model(2'b00, 32'd1000, 32'hFFFF_FFF9)) begin
        errors++;
        $display("FAIL stall_hold%0d hazir=%b sonuc=%h want hazir=1 sonuc=%h", i, hazir_o, sonuc_o,
                 model(2'b00, 32'd1000, 32'hFFFF_FFF9));
      end
    end
    durdur_i = 1'b0;
    release_op();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hazir_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_no_restart%0d hazir got %b want 1", i, hazir_o);
      end
      next_cycle();
    end
  endtask

  task automatic test_abort();
    @(negedge clk_i);
    basla_i = 1'b1; islem_i = 2'b01; bolunen_i = 32'hDEAD_BEEF; bolen_i = 32'd13;
    repeat (11) next_cycle();
    iptal_i = 1'b1;
    next_cycle();
    iptal_i = 1'b0; basla_i = 1'b0;
    #1;
    checks++;
    if (hazir_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_bos hazir got %b want 1", hazir_o);
    end
    run_check("after_abort_9_3", 2'b01, 32'd9, 32'd3, 32'd3);
    release_op();
    // Flush in BOS wins over basla_i: nothing may be accepted that cycle.
    @(negedge clk_i);
    basla_i = 1'b1; iptal_i = 1'b1; islem_i = 2'b01; bolunen_i = 32'd50; bolen_i = 32'd5;
    next_cycle();
    basla_i = 1'b0; iptal_i = 1'b0;
    #1;
    checks++;
    if (hazir_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_priority hazir got %b want 1", hazir_o);
    end
  endtask

  task automatic test_back_to_back();
    run_check("b2b_0", 2'b01, 32'd77, 32'd5, 32'd15);
    run_check("b2b_1", 2'b11, 32'd77, 32'd5, 32'd2);
    run_check("b2b_2", 2'b00, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_check("b2b_3", 2'b10, 32'hFFFF_FF9C, 32'd7, model(2'b10, 32'hFFFF_FF9C, 32'd7));
    release_op();
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    basla_i = 1'b1; islem_i = 2'b01; bolunen_i = 32'd500; bolen_i = 32'd3;
    repeat (5) next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; basla_i = 1'b0;
    #1;
    checks++;
    if (hazir_o !== 1'b1 || sonuc_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid hazir=%b sonuc=%h want hazir=1 sonuc=0", hazir_o, sonuc_o);
    end
    run_check("after_reset", 2'b01, 32'd500, 32'd3, 32'd166);
    release_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
